// File: rtl/code2of5_pkg.sv
// Shared constants for the 2-of-5 scanned display: codeword table, 7-segment
// patterns ({g,f,e,d,c,b,a}) and a codeword decoder that also flags invalid input.
package code2of5_pkg;

  localparam logic [4:0] CW_0 = 5'b11000;
  localparam logic [4:0] CW_1 = 5'b00011;
  localparam logic [4:0] CW_2 = 5'b00101;
  localparam logic [4:0] CW_3 = 5'b00110;
  localparam logic [4:0] CW_4 = 5'b01001;
  localparam logic [4:0] CW_5 = 5'b01010;
  localparam logic [4:0] CW_6 = 5'b01100;
  localparam logic [4:0] CW_7 = 5'b10001;
  localparam logic [4:0] CW_8 = 5'b10010;
  localparam logic [4:0] CW_9 = 5'b10100;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic       valid;
    logic [6:0] seg;
  } decode_t;

  // Anything outside the ten table entries (including wrong popcount) is invalid and decodes blank.
  function automatic decode_t decode_code(input logic [4:0] code);
    decode_t r;
    r.valid = 1'b1;
    r.seg   = SEG_BLANK;
    case (code)
      CW_0:    r.seg = SEG_0;
      CW_1:    r.seg = SEG_1;
      CW_2:    r.seg = SEG_2;
      CW_3:    r.seg = SEG_3;
      CW_4:    r.seg = SEG_4;
      CW_5:    r.seg = SEG_5;
      CW_6:    r.seg = SEG_6;
      CW_7:    r.seg = SEG_7;
      CW_8:    r.seg = SEG_8;
      CW_9:    r.seg = SEG_9;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic code_valid(input logic [4:0] code);
    decode_t r;
    r = decode_code(code);
    return r.valid;
  endfunction

endpackage

// File: rtl/code2of5_seg_decode.sv
// Combinational 2-of-5 codeword to 7-segment decoder with a valid flag.
module code2of5_seg_decode (
  input  logic [4:0] code,
  output logic [6:0] seg,
  output logic       valid
);
  import code2of5_pkg::*;

  decode_t dec;

  assign dec   = decode_code(code);
  assign seg   = dec.seg;
  assign valid = dec.valid;

endmodule

// File: rtl/code2of5_scan_display.sv
// Multiplexed 7-segment driver for N_DIGITS 2-of-5 codewords with blink-on-error,
// global blanking and a sticky error flag.
module code2of5_scan_display #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ERR_SHOW_E   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*N_DIGITS-1:0] code_in,
  input  logic                  load,
  input  logic                  blank,
  input  logic                  err_clr,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic [N_DIGITS-1:0]   err_vec,
  output logic                  err_sticky
);
  import code2of5_pkg::*;

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [5*N_DIGITS-1:0] held;
  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  phase;
  logic [4:0]            cur_code;
  logic [6:0]            dec_seg;
  logic                  dec_valid;
  logic [6:0]            slot_seg;
  logic [6:0]            slot_next;
  logic                  load_bad;
  logic                  tick;

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    cur_code = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) cur_code = held[5*k +: 5];
    end
  end

  code2of5_seg_decode u_decode (
    .code  (cur_code),
    .seg   (dec_seg),
    .valid (dec_valid)
  );

  always_comb begin
    err_vec  = '0;
    load_bad = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      err_vec[k] = !code_valid(held[5*k +: 5]);
      load_bad   = load_bad | !code_valid(code_in[5*k +: 5]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      presc <= '0;
      if (idx == IDX_LAST) begin
        idx <= '0;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // The pattern is latched at the first cycle of each slot so a mid-slot load waits for the next slot.
  always_comb begin
    slot_next = slot_seg;
    if (presc == '0) begin
      if (dec_valid)                      slot_next = dec_seg;
      else if (ERR_SHOW_E != 0 && !phase) slot_next = SEG_E;
      else                                slot_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_seg <= SEG_BLANK;
      seg      <= SEG_BLANK;
      dig_en   <= '0;
    end else begin
      slot_seg <= slot_next;
      seg      <= blank ? SEG_BLANK : slot_next;
      dig_en   <= N_DIGITS'(1) << idx;
    end
  end

  // A load carrying a bad digit outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held       <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (load) held <= code_in;
      if (load && load_bad) err_sticky <= 1'b1;
      else if (err_clr)     err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_code2of5_scan_display.sv
// Scoreboard bench: a slot/frame arithmetic model predicts every post-edge output,
// a monitor pops and compares just after each rising edge.
module tb_code2of5_scan_display;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5*N-1:0] code_in = '0;
  logic          load = 1'b0;
  logic          blank = 1'b0;
  logic          err_clr = 1'b0;
  logic [6:0]    seg;
  logic [N-1:0]  dig_en;
  logic [N-1:0]  err_vec;
  logic          err_sticky;

  code2of5_scan_display #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ERR_SHOW_E(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .load(load), .blank(blank),
    .err_clr(err_clr), .seg(seg), .dig_en(dig_en), .err_vec(err_vec), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] dig_en;
    logic [N-1:0] err_vec;
    logic         err_sticky;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [4:0] ref_code [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};
  logic [6:0] ref_seg  [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [6:0] REF_E = 7'b1111001;

  logic [4:0] m_held [N];
  logic       m_sticky;
  logic [6:0] m_slot;
  int         t;

  function automatic int ref_digit(input logic [4:0] c);
    for (int i = 0; i < 10; i++) if (c == ref_code[i]) return i;
    return -1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_held[k] = 5'b00000;
    m_sticky = 1'b0;
    m_slot   = 7'b0;
    t        = 0;
  endtask

  // Called at a falling edge: drives inputs for the next rising edge and queues its expected result.
  task automatic apply_stimulus(input logic ld, input logic [5*N-1:0] code,
                                input logic bl, input logic clr);
    exp_t e;
    int   idx, ph, d;
    logic any_bad;
    load = ld; code_in = code; blank = bl; err_clr = clr;
    idx = (t / SD) % N;
    ph  = (t / (SD * N * BF)) % 2;
    if (t % SD == 0) begin
      d = ref_digit(m_held[idx]);
      m_slot = (d >= 0) ? ref_seg[d] : ((ph == 0) ? REF_E : 7'b0);
    end
    e.seg    = bl ? 7'b0 : m_slot;
    e.dig_en = N'(1) << idx;
    any_bad = 1'b0;
    for (int k = 0; k < N; k++) if (ref_digit(code[5*k +: 5]) < 0) any_bad = 1'b1;
    if (ld) for (int k = 0; k < N; k++) m_held[k] = code[5*k +: 5];
    if (ld && any_bad) m_sticky = 1'b1;
    else if (clr)      m_sticky = 1'b0;
    for (int k = 0; k < N; k++) e.err_vec[k] = (ref_digit(m_held[k]) < 0);
    e.err_sticky = m_sticky;
    sb_q.push_back(e);
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, bl, 1'b0);
  endtask

  task automatic check_reset_state();
    check_output("rst_seg",    32'(seg),        32'h0);
    check_output("rst_dig_en", 32'(dig_en),     32'h0);
    check_output("rst_err_vec", 32'(err_vec),   32'hF);
    check_output("rst_sticky", 32'(err_sticky), 32'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output("seg",        32'(seg),        32'(e.seg));
      check_output("dig_en",     32'(dig_en),     32'(e.dig_en));
      check_output("err_vec",    32'(err_vec),    32'(e.err_vec));
      check_output("err_sticky", 32'(err_sticky), 32'(e.err_sticky));
    end
  end

  function automatic logic [5*N-1:0] rand_code();
    logic [5*N-1:0] c;
    for (int k = 0; k < N; k++)
      c[5*k +: 5] = ($urandom_range(3) != 0) ? ref_code[$urandom_range(9)] : 5'($urandom);
    return c;
  endfunction

  initial begin
    logic bl;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    $display("[TB] digits 9,7,1,0 scan");
    apply_stimulus(1'b1, {5'b10100, 5'b10001, 5'b00011, 5'b11000}, 1'b0, 1'b0);
    idle(40, 1'b0);

    $display("[TB] invalid digit 2 blink");
    apply_stimulus(1'b1, {5'b10100, 5'b11100, 5'b00011, 5'b11000}, 1'b0, 1'b0);
    idle(80, 1'b0);

    $display("[TB] err_clr against load");
    apply_stimulus(1'b1, {5'b10100, 5'b10001, 5'b00011, 5'b11000}, 1'b0, 1'b1);
    idle(3, 1'b0);
    apply_stimulus(1'b1, {5'b10100, 5'b00000, 5'b00011, 5'b11000}, 1'b0, 1'b0);
    idle(2, 1'b0);
    apply_stimulus(1'b1, {5'b11111, 5'b10001, 5'b00011, 5'b11000}, 1'b0, 1'b1);
    idle(3, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    idle(5, 1'b0);

    $display("[TB] blank mid-scan");
    idle(20, 1'b1);
    idle(20, 1'b0);

    $display("[TB] randomized traffic");
    bl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) bl = ~bl;
      apply_stimulus($urandom_range(7) == 0, rand_code(), bl, $urandom_range(9) == 0);
    end
    idle(4, 1'b0);

    $display("[TB] reset mid-slot 2");
    while ((t % (SD * N)) != 9) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_state();
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    model_reset();
    idle(20, 1'b0);

    @(posedge clk);
    #2;
    check_output("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code2of5_scan_display.md
CODE2OF5_SCAN_DISPLAY -- requirements
Module: code2of5_scan_display

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter SCAN_DIV, default 1000, clocks per digit slot (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 Parameter ERR_SHOW_E, default 1: 1 = invalid digit shows blinking "E"; 0 = invalid digit blanked.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 code_in  in  5*N_DIGITS  2-of-5 codewords; digit k = code_in[5k+4:5k], bit 4 = E1 ... bit 0 = E5.
REQ-008 load  in  1  capture code_in into display register this cycle.
REQ-009 blank  in  1  level; forces all segments off while high.
REQ-010 err_clr  in  1  clears sticky error flags.
REQ-011 seg  out  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-012 dig_en  out  N_DIGITS  one-hot digit enable, active-high, registered.
REQ-013 err_vec  out  N_DIGITS  per-digit invalid flag of the currently held codewords (combinational from held register).
REQ-014 err_sticky  out  1  set when any loaded digit was invalid; held until err_clr.

Function
REQ-015 Codeword table (E1..E5): 0=11000, 1=00011, 2=00101, 3=00110, 4=01001, 5=01010, 6=01100, 7=10001, 8=10010, 9=10100.
REQ-016 Any codeword not in the table (popcount != 2 included) is invalid.
REQ-017 Segment patterns: standard 7-seg for 0-9; "E" = a,d,e,f,g; blank = 0000000.
REQ-018 On load high, held register takes code_in at that rising edge; no other event changes it.
REQ-019 Prescaler counts 0..SCAN_DIV-1 and wraps; wrap cycle is the scan tick.
REQ-020 Digit index increments on scan tick, wraps N_DIGITS-1 -> 0; frame counter increments on each index wrap.
REQ-021 Blink phase toggles every BLINK_FRAMES frames; phase 0 = "E" visible, phase 1 = blank.
REQ-022 seg and dig_en update one clock after index change (one-cycle registered latency); dig_en always exactly one-hot, including when blank high.
REQ-023 Displayed digit is decoded from held register; a load becomes visible at that digit's next slot, no mid-slot change beyond the one-cycle register update.
REQ-024 Invalid digit: ERR_SHOW_E=1 shows "E" in phase 0, blank in phase 1; ERR_SHOW_E=0 always blank.
REQ-025 blank high forces seg=0 on the next clock; counters keep running.
REQ-026 err_sticky sets on the clock after a load whose code_in contains any invalid digit.
REQ-027 err_clr and an error-setting load in the same cycle: set wins, err_sticky stays 1.
REQ-028 N_DIGITS=1: index stays 0, dig_en constant 1, frame counter increments every tick.

Reset
REQ-029 rst_n low asynchronously: held register all-zero codewords (invalid), prescaler 0, index 0, frame counter 0, blink phase 0, err_sticky 0, seg 0, dig_en 0.
REQ-030 First clock after rst_n release drives dig_en bit 0; err_vec reads all ones until first load; reset mid-scan restarts at digit 0.

Structure
REQ-031 Package code2of5_pkg holds codeword table constants, 7-seg pattern constants (digits, E, blank) and a codeword-to-segment decode function with valid flag.
REQ-032 One combinational sub-module code2of5_seg_decode (5-bit code in, 7-bit seg and valid out), instanced once on the muxed digit.

Verification (N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ERR_SHOW_E=1)
REQ-033 Reset, load code_in for digits 3..0 = 10100,10001,00011,11000 -> slots 0..3 show seg 0111111,0000110,0000111,1101111; each dig_en bit held 4 clocks.
REQ-034 Load digit 2 = 11100 -> err_vec=0100, err_sticky=1 next clock, slot 2 alternates "E" 1111001 / 0000000 every 2 frames (32 clocks).
REQ-035 err_clr with load of all-valid data same cycle -> err_sticky=0; repeat with invalid data -> err_sticky stays 1.
REQ-036 blank high for 20 clocks mid-scan -> seg=0 from next clock, dig_en keeps rotating, display resumes at correct slot after release.
REQ-037 rst_n pulsed low mid-slot 2 -> seg=0, dig_en=0 immediately without clock; after release scan restarts at digit 0, err_vec=1111.
